// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU bit-slice control sequencer
// Latches an opcode on Start, holds one function group for a settle window, then captures flags.
module alu_ctrl_seq #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Start,
    input  logic [3:0] Opcode,
    input  logic [3:0] ShAmt,
    input  logic       ShSrcB,
    input  logic       COut,
    input  logic       nZ,
    input  logic       AluSign,
    output logic       SUB,
    output logic       ZeroA,
    output logic       CIn_Slice,
    output logic       FAOut,
    output logic       AND,
    output logic       OR,
    output logic       XOR,
    output logic       NOT,
    output logic       NAND,
    output logic       NOR,
    output logic       Sh8,
    output logic       Sh4,
    output logic       Sh2,
    output logic       Sh1,
    output logic       ShB,
    output logic       ShL,
    output logic       ShR,
    output logic       ShOut,
    output logic       ResultWe,
    output logic       Busy,
    output logic       Done,
    output logic       Err,
    output logic       ZFlag,
    output logic       NFlag,
    output logic       CFlag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic sub;
        logic zero_a;
        logic cin;
        logic fa_out;
        logic l_and;
        logic l_or;
        logic l_xor;
        logic l_not;
        logic l_nand;
        logic l_nor;
        logic sh8;
        logic sh4;
        logic sh2;
        logic sh1;
        logic shb;
        logic shl;
        logic shr;
        logic sh_out;
    } ctrl_t;

    localparam logic [3:0] OP_CMP     = 4'd5;
    localparam logic [3:0] OP_PASSB   = 4'd14;
    localparam logic [3:0] OP_ILLEGAL = 4'd15;
    localparam logic [3:0] CNT_LOAD   = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] op_q;
    ctrl_t      ctrl_q;
    logic       we_en_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       z_q;
    logic       n_q;
    logic       c_q;

    // Carry-in for ADC/SBC is frozen from CFlag at accept time.
    function automatic ctrl_t decode(input logic [3:0] op, input logic [3:0] amt,
                                     input logic srcb, input logic cf);
        ctrl_t c;
        c = '0;
        case (op)
            4'd0:  c.fa_out = 1'b1;
            4'd1:  begin c.fa_out = 1'b1; c.cin = cf; end
            4'd2,
            4'd5:  begin c.fa_out = 1'b1; c.sub = 1'b1; c.cin = 1'b1; end
            4'd3:  begin c.fa_out = 1'b1; c.sub = 1'b1; c.cin = cf; end
            4'd4:  begin c.fa_out = 1'b1; c.sub = 1'b1; c.zero_a = 1'b1; c.cin = 1'b1; end
            4'd6:  c.l_and  = 1'b1;
            4'd7:  c.l_or   = 1'b1;
            4'd8:  c.l_xor  = 1'b1;
            4'd9:  c.l_not  = 1'b1;
            4'd10: c.l_nand = 1'b1;
            4'd11: c.l_nor  = 1'b1;
            4'd12, 4'd13: begin
                c.sh_out = 1'b1;
                c.shl    = (op == 4'd12);
                c.shr    = (op == 4'd13);
                {c.sh8, c.sh4, c.sh2, c.sh1} = amt;
                c.shb    = srcb;
            end
            4'd14: begin c.fa_out = 1'b1; c.zero_a = 1'b1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            ctrl_q  <= '0;
            we_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (Start) begin
                        op_q    <= Opcode;
                        cnt_q   <= CNT_LOAD;
                        ctrl_q  <= decode(Opcode, ShAmt, ShSrcB, c_q);
                        we_en_q <= (Opcode != OP_CMP) && (Opcode != OP_ILLEGAL);
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        if (op_q != OP_ILLEGAL) begin
                            z_q <= ~nZ;
                            n_q <= AluSign;
                            if (op_q <= OP_CMP || op_q == OP_PASSB)
                                c_q <= COut;
                        end
                        ctrl_q  <= '0;
                        we_en_q <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= (op_q == OP_ILLEGAL);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ResultWe  = (state_q == EXEC) && (cnt_q == 4'd0) && we_en_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;
    assign ZFlag     = z_q;
    assign NFlag     = n_q;
    assign CFlag     = c_q;

    assign SUB       = ctrl_q.sub;
    assign ZeroA     = ctrl_q.zero_a;
    assign CIn_Slice = ctrl_q.cin;
    assign FAOut     = ctrl_q.fa_out;
    assign AND       = ctrl_q.l_and;
    assign OR        = ctrl_q.l_or;
    assign XOR       = ctrl_q.l_xor;
    assign NOT       = ctrl_q.l_not;
    assign NAND      = ctrl_q.l_nand;
    assign NOR       = ctrl_q.l_nor;
    assign Sh8       = ctrl_q.sh8;
    assign Sh4       = ctrl_q.sh4;
    assign Sh2       = ctrl_q.sh2;
    assign Sh1       = ctrl_q.sh1;
    assign ShB       = ctrl_q.shb;
    assign ShL       = ctrl_q.shl;
    assign ShR       = ctrl_q.shr;
    assign ShOut     = ctrl_q.sh_out;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - scoreboard bench for alu_ctrl_seq
// Directed opcode vectors push expectations; a monitor pops and checks on each Done.
module tb_alu_ctrl_seq;

    localparam int SETTLE = 2;

    localparam logic [17:0] M_SUB  = 18'h20000;
    localparam logic [17:0] M_ZA   = 18'h10000;
    localparam logic [17:0] M_CIN  = 18'h08000;
    localparam logic [17:0] M_FA   = 18'h04000;
    localparam logic [17:0] M_AND  = 18'h02000;
    localparam logic [17:0] M_OR   = 18'h01000;
    localparam logic [17:0] M_XOR  = 18'h00800;
    localparam logic [17:0] M_NOT  = 18'h00400;
    localparam logic [17:0] M_NAND = 18'h00200;
    localparam logic [17:0] M_NOR  = 18'h00100;
    localparam logic [17:0] M_SH8  = 18'h00080;
    localparam logic [17:0] M_SH4  = 18'h00040;
    localparam logic [17:0] M_SH2  = 18'h00020;
    localparam logic [17:0] M_SH1  = 18'h00010;
    localparam logic [17:0] M_SHB  = 18'h00008;
    localparam logic [17:0] M_SHL  = 18'h00004;
    localparam logic [17:0] M_SHR  = 18'h00002;
    localparam logic [17:0] M_SHO  = 18'h00001;

    logic Clock = 1'b0, nReset = 1'b0, Start = 1'b0;
    logic [3:0] Opcode = '0, ShAmt = '0;
    logic ShSrcB = 1'b0, COut = 1'b0, nZ = 1'b1, AluSign = 1'b0;
    logic SUB, ZeroA, CIn_Slice, FAOut, AND, OR, XOR, NOT, NAND, NOR;
    logic Sh8, Sh4, Sh2, Sh1, ShB, ShL, ShR, ShOut;
    logic ResultWe, Busy, Done, Err, ZFlag, NFlag, CFlag;

    alu_ctrl_seq #(.SETTLE_CYCLES(SETTLE)) dut (
        .Clock(Clock), .nReset(nReset), .Start(Start), .Opcode(Opcode), .ShAmt(ShAmt),
        .ShSrcB(ShSrcB), .COut(COut), .nZ(nZ), .AluSign(AluSign),
        .SUB(SUB), .ZeroA(ZeroA), .CIn_Slice(CIn_Slice), .FAOut(FAOut),
        .AND(AND), .OR(OR), .XOR(XOR), .NOT(NOT), .NAND(NAND), .NOR(NOR),
        .Sh8(Sh8), .Sh4(Sh4), .Sh2(Sh2), .Sh1(Sh1), .ShB(ShB), .ShL(ShL), .ShR(ShR),
        .ShOut(ShOut), .ResultWe(ResultWe), .Busy(Busy), .Done(Done), .Err(Err),
        .ZFlag(ZFlag), .NFlag(NFlag), .CFlag(CFlag)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  amt;
        logic        srcb;
        logic        cout;
        logic        nz;
        logic        sign;
        logic [17:0] ctrl;
        logic        we;
        logic        err;
        logic        z;
        logic        n;
        logic        c;
        logic        pulse;
    } vec_t;

    typedef struct packed {
        logic [17:0] ctrl;
        logic        we;
        logic        err;
        logic        z;
        logic        n;
        logic        c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_pushed = 0;
    int   done_seen = 0;

    logic [17:0] ctrl_now;
    assign ctrl_now = {SUB, ZeroA, CIn_Slice, FAOut, AND, OR, XOR, NOT, NAND, NOR,
                       Sh8, Sh4, Sh2, Sh1, ShB, ShL, ShR, ShOut};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    task automatic add_vec(input logic [3:0] op, input logic [3:0] amt, input logic srcb,
                           input logic cout, input logic nz, input logic sign,
                           input logic [17:0] ctrl, input logic we, input logic err,
                           input logic z, input logic n, input logic c, input logic pulse);
        vecs.push_back('{op, amt, srcb, cout, nz, sign, ctrl, we, err, z, n, c, pulse});
    endtask

    task automatic issue(input vec_t v, input logic expect_done);
        bit idle_seen;
        @(posedge Clock); #1;
        Start = 1'b1; Opcode = v.op; ShAmt = v.amt; ShSrcB = v.srcb;
        COut = v.cout; nZ = v.nz; AluSign = v.sign;
        if (expect_done) begin
            sb.push_back('{v.ctrl, v.we, v.err, v.z, v.n, v.c});
            n_pushed++;
        end
        @(posedge Clock); #1;
        Start = 1'b0;
        if (v.pulse) begin
            @(posedge Clock); #1 Start = 1'b1;
            @(posedge Clock); #1 Start = 1'b0;
        end
        if (expect_done) begin
            idle_seen = 1'b0;
            for (int k = 0; k < 30 && !idle_seen; k++) begin
                @(negedge Clock);
                if (!Busy) idle_seen = 1'b1;
            end
            chk("op_completes_in_budget", 32'(idle_seen), 32'd1);
        end
    endtask

    // Monitor: accumulates EXEC observations, compares against the scoreboard on Done.
    initial begin
        logic [17:0] first_ctrl;
        bit   in_op, const_ok, onehot_ok, after_done;
        int   busy_cnt, we_cnt, we_cycle;
        exp_t e;
        in_op = 0; after_done = 0;
        busy_cnt = 0; we_cnt = 0; we_cycle = 0;
        const_ok = 1; onehot_ok = 1; first_ctrl = '0;
        forever begin
            @(negedge Clock);
            if (!nReset) begin
                in_op = 0;
                after_done = 0;
            end else begin
                if (after_done) begin
                    chk("idle_after_done", {13'd0, Busy, ResultWe, ctrl_now}, 32'd0);
                    after_done = 0;
                end
                if (Busy && !Done) begin
                    if (!in_op) begin
                        in_op = 1; first_ctrl = ctrl_now;
                        busy_cnt = 0; we_cnt = 0; we_cycle = 0;
                        const_ok = 1; onehot_ok = 1;
                    end
                    busy_cnt++;
                    if (ctrl_now !== first_ctrl) const_ok = 0;
                    if ($countones({FAOut, AND, OR, XOR, NOT, NAND, NOR, ShOut}) > 1) onehot_ok = 0;
                    if (ResultWe) begin we_cnt++; we_cycle = busy_cnt; end
                end
                if (Done) begin
                    done_seen++;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        busy_cnt++;
                        chk("exec_ctrl", 32'(first_ctrl), 32'(e.ctrl));
                        chk("ctrl_constant", 32'(const_ok), 32'd1);
                        chk("one_group_active", 32'(onehot_ok), 32'd1);
                        chk("busy_cycles", 32'(busy_cnt), 32'(SETTLE + 1));
                        chk("we_count", 32'(we_cnt), 32'(e.we));
                        if (e.we) chk("we_last_exec_cycle", 32'(we_cycle), 32'(SETTLE));
                        chk("done_cycle_ctrl_zero", {13'd0, ResultWe, ctrl_now}, 32'd0);
                        chk("err", 32'(Err), 32'(e.err));
                        chk("zflag", 32'(ZFlag), 32'(e.z));
                        chk("nflag", 32'(NFlag), 32'(e.n));
                        chk("cflag", 32'(CFlag), 32'(e.c));
                    end
                    in_op = 0;
                    after_done = 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_before;
        //       op     amt     sb cout nz sg ctrl                                  we er z  n  c  pulse
        add_vec(4'd0,  4'd0,   0, 0,  1, 0, M_FA,                                 1, 0, 0, 0, 0, 0);
        add_vec(4'd2,  4'd0,   0, 1,  0, 1, M_FA|M_SUB|M_CIN,                     1, 0, 1, 1, 1, 0);
        add_vec(4'd1,  4'd0,   0, 0,  1, 0, M_FA|M_CIN,                           1, 0, 0, 0, 0, 0);
        add_vec(4'd3,  4'd0,   0, 1,  1, 0, M_FA|M_SUB,                           1, 0, 0, 0, 1, 0);
        add_vec(4'd6,  4'd0,   0, 0,  0, 0, M_AND,                                1, 0, 1, 0, 1, 0);
        add_vec(4'd7,  4'd0,   0, 0,  1, 1, M_OR,                                 1, 0, 0, 1, 1, 0);
        add_vec(4'd8,  4'd0,   0, 0,  1, 0, M_XOR,                                1, 0, 0, 0, 1, 0);
        add_vec(4'd9,  4'd0,   0, 0,  1, 1, M_NOT,                                1, 0, 0, 1, 1, 0);
        add_vec(4'd10, 4'd0,   0, 0,  0, 0, M_NAND,                               1, 0, 1, 0, 1, 0);
        add_vec(4'd11, 4'd0,   0, 0,  1, 0, M_NOR,                                1, 0, 0, 0, 1, 0);
        add_vec(4'd12, 4'b1011,1, 0,  1, 1, M_SHO|M_SHL|M_SHB|M_SH8|M_SH2|M_SH1,  1, 0, 0, 1, 1, 0);
        add_vec(4'd13, 4'd0,   0, 0,  0, 0, M_SHO|M_SHR,                          1, 0, 1, 0, 1, 0);
        add_vec(4'd4,  4'd0,   0, 0,  1, 1, M_FA|M_SUB|M_ZA|M_CIN,                1, 0, 0, 1, 0, 0);
        add_vec(4'd14, 4'd0,   0, 1,  1, 0, M_FA|M_ZA,                            1, 0, 0, 0, 1, 0);
        add_vec(4'd5,  4'd0,   0, 0,  0, 0, M_FA|M_SUB|M_CIN,                     0, 0, 1, 0, 0, 0);
        add_vec(4'd15, 4'hF,   1, 1,  1, 1, 18'd0,                                0, 1, 1, 0, 0, 0);
        add_vec(4'd0,  4'd0,   0, 1,  1, 0, M_FA,                                 1, 0, 0, 0, 1, 1);

        repeat (3) @(posedge Clock);
        #2;
        chk("reset_outputs", {7'd0, ResultWe, Busy, Done, Err, ZFlag, NFlag, CFlag, ctrl_now}, 32'd0);
        @(negedge Clock); nReset = 1'b1;

        foreach (vecs[i]) issue(vecs[i], 1'b1);

        // Abort an ADD mid-EXEC with an asynchronous reset.
        done_before = done_seen;
        issue('{4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, M_FA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b0);
        #2 nReset = 1'b0;
        #1 chk("async_reset_clears", {7'd0, ResultWe, Busy, Done, Err, ZFlag, NFlag, CFlag, ctrl_now}, 32'd0);
        @(negedge Clock); nReset = 1'b1;
        repeat (10) @(negedge Clock);
        chk("no_done_after_abort", 32'(done_seen), 32'(done_before));
        chk("idle_after_abort", {31'd0, Busy}, 32'd0);

        issue('{4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, M_FA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}, 1'b1);

        repeat (4) @(negedge Clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(n_pushed));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
